// File: rtl/uart_result_sender.sv
// Serialises a scalar result or a vector of buffer elements onto an 8N1 UART line.
// Elements are ELEM_BYTES wide and are sent little-endian with no gap between bytes.
module uart_result_sender #(
    parameter int unsigned CLKS_PER_BIT = 100,
    parameter int unsigned N_ELEMS      = 1024,
    parameter int unsigned ELEM_BYTES   = 1,
    parameter int unsigned ADDR_W       = $clog2(N_ELEMS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    mode,
    input  logic [ADDR_W:0]         len,
    input  logic [8*ELEM_BYTES-1:0] scalar_in,
    output logic [ADDR_W-1:0]       rd_addr,
    input  logic [8*ELEM_BYTES-1:0] rd_data,
    output logic                    uart_tx,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BYTE_W = (ELEM_BYTES > 1) ? $clog2(ELEM_BYTES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(ELEM_BYTES - 1);
    localparam logic [ADDR_W:0]   MAX_LEN   = (ADDR_W + 1)'(N_ELEMS);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StStart,
        StData,
        StStop
    } state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [2:0]              bit_q;
    logic [BYTE_W-1:0]       byte_q;
    logic [8*ELEM_BYTES-1:0] shift_q;
    logic [ADDR_W:0]         len_q;
    logic                    mode_q;
    logic                    bit_end;
    logic                    last_elem;

    // rd_addr doubles as the element index.
    always_comb begin
        bit_end   = (cnt_q == CNT_LAST);
        last_elem = ({1'b0, rd_addr} == len_q - (ADDR_W + 1)'(1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            len_q   <= '0;
            mode_q  <= 1'b0;
            rd_addr <= '0;
            uart_tx <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        mode_q <= mode;
                        cnt_q  <= '0;
                        bit_q  <= '0;
                        byte_q <= '0;
                        if (!mode) begin
                            shift_q <= scalar_in;
                            uart_tx <= 1'b0;
                            busy    <= 1'b1;
                            state_q <= StStart;
                        end else if (len == '0) begin
                            done <= 1'b1;
                        end else begin
                            len_q   <= (len > MAX_LEN) ? MAX_LEN : len;
                            rd_addr <= '0;
                            busy    <= 1'b1;
                            state_q <= StFetch;
                        end
                    end
                end
                StFetch: state_q <= StLoad;
                StLoad: begin
                    shift_q <= rd_data;
                    uart_tx <= 1'b0;
                    state_q <= StStart;
                end
                StStart: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        uart_tx <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        state_q <= StData;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StData: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            bit_q   <= '0;
                            uart_tx <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            uart_tx <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (byte_q != BYTE_LAST) begin
                            // Next byte already sits in the low bits of shift_q.
                            byte_q  <= byte_q + BYTE_W'(1);
                            uart_tx <= 1'b0;
                            state_q <= StStart;
                        end else begin
                            byte_q <= '0;
                            if (mode_q && !last_elem) begin
                                rd_addr <= rd_addr + ADDR_W'(1);
                                state_q <= StFetch;
                            end else begin
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                state_q <= StIdle;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/uart_result_sender.md
Name: uart_result_sender

Overview:
Parametrised successor to the accelerator's UART output stage. Serialises either one scalar result or a vector of results, each of ELEM_BYTES bytes, onto an integrated 8N1 UART transmitter. In vector mode it fetches elements from the result buffer through a 1-cycle-latency read port. It pulses done when the last stop bit has been sent.

Parameters:
CLKS_PER_BIT, 100, clock cycles per UART bit (>=2)
N_ELEMS, 1024, result buffer depth in elements (>=1)
ELEM_BYTES, 1, bytes per element, range 1..4
ADDR_W, $clog2(N_ELEMS), read address width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only while idle
mode  in  1  1 = vector, 0 = scalar
len  in  ADDR_W+1  vector element count, latched on start
scalar_in  in  8*ELEM_BYTES  scalar value, latched on start
rd_addr  out  ADDR_W  buffer read address, registered
rd_data  in  8*ELEM_BYTES  buffer data, valid 1 cycle after rd_addr
uart_tx  out  1  serial line, idle high
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle completion pulse

Behaviour:
- Reset values: uart_tx=1, busy=0, done=0, rd_addr=0, state IDLE. Reset mid-frame takes effect next edge: line goes high, no done pulse, counters cleared.
- FSM states: IDLE, FETCH, LOAD, START_BIT, DATA_BITS, STOP_BIT.
- IDLE:
  - start=1 with mode=0: latch scalar_in into the shift register, go to START_BIT.
  - start=1 with mode=1: latch len, clamping values above N_ELEMS to N_ELEMS. If len=0, pulse done next cycle, send no frames, return to IDLE. Otherwise set element index and rd_addr to 0 and go to FETCH.
- FETCH: 1 cycle; rd_addr is held so the buffer can respond. Go to LOAD.
- LOAD: latch rd_data into the shift register; go to START_BIT.
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit is held exactly CLKS_PER_BIT cycles, so one byte takes 10*CLKS_PER_BIT cycles.
- Byte order within an element is little-endian: byte 0 (bits 7:0) goes first.
- No idle gap between bytes of the same element: the stop bit is followed immediately by the next start bit.
- After the last byte of element k, if more elements remain: increment the index, drive rd_addr=k+1, go to FETCH. This leaves a 2-cycle idle-high gap between elements.
- After the last byte of the last element, or of the scalar: go to IDLE and assert done for exactly 1 cycle in that IDLE cycle. busy is already 0 in that cycle.
- start asserted in the done cycle is accepted (back-to-back transfers).
- start while busy=1 is ignored. Changes to mode, len or scalar_in during a transfer are ignored.
- Latency from the start-accept cycle t:
  - Scalar: line drops at t+1; done at t+1+ELEM_BYTES*10*CLKS_PER_BIT.
  - Vector: rd_addr=0 valid during t+1; line drops at t+3. Each element occupies 2+ELEM_BYTES*10*CLKS_PER_BIT cycles; done at t+1+len*(2+ELEM_BYTES*10*CLKS_PER_BIT).
- Counters: the bit-time counter counts 0..CLKS_PER_BIT-1, bit index 0..7, byte index 0..ELEM_BYTES-1, element index 0..len-1. None wraps silently; each terminal count drives a state transition.

Test Plan:
Bench parameters for all scenarios: CLKS_PER_BIT=4, N_ELEMS=4, ELEM_BYTES=2.
1. Reset, then idle 20 cycles -> uart_tx=1, busy=0, done=0, rd_addr=0 throughout.
2. Scalar: start at t, mode=0, scalar_in=0xA55A -> line low t+1..t+4; data bits 0,1,0,1,1,0,1,0 (byte 0x5A), then stop, then byte 0xA5; done pulses only at t+81.
3. Vector: mem[i]=0x0100+i, start at t, mode=1, len=4 -> rd_addr 0,1,2,3; byte stream 00 01 01 01 02 01 03 01; 2-cycle high gap between elements; done at t+329.
4. Vector, len=0 -> no line activity, done at t+1. Vector, len=7 -> clamped to 4 elements, identical to scenario 3.
5. Start re-pulsed mid-transfer, with scalar_in changed -> output is unchanged, one done only. Start held high through the done cycle -> second transfer begins; line drops in the cycle after done.
6. Reset asserted during a data bit of element 1 -> uart_tx=1 from the next cycle; no done; a fresh scalar transfer afterwards is bit-exact.
